// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with mid-bit sampling and valid/ready output.
//
// A falling edge on the synchronized line starts a frame. The start bit is
// confirmed at mid-bit, DATA_WIDTH payload bits are sampled LSB first one bit
// period apart, and the stop bit is checked at its own mid-point. A good frame
// is handed to the host through a one-word output register that holds its
// contents until the host accepts them.
//
// Optional feature (compile-time macro UART_RX_MAJORITY_EN):
//   defined   -- each sample point takes a 2-of-3 majority of rx_s over the
//                last three cycles, rejecting single-cycle line glitches.
//   undefined -- each sample point uses rx_s at the single cycle clk_cnt==0.
//
// Ports:
//   clk             system clock, the only clock
//   rstn            asynchronous active-low reset
//   rx_sig          serial line, idle high, asynchronous to clk
//   data_to_host    received payload word
//   valid_to_host   data_to_host holds an unconsumed word
//   ready_from_host host takes the word when valid_to_host && ready_from_host
//   frame_err       one-cycle pulse: stop bit sampled low
//   overrun_err     one-cycle pulse: a completed word was dropped
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data_to_host,
  output logic                  valid_to_host,
  input  logic                  ready_from_host,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W            = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; both flops reset to the idle (high) line level so a
  // reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic rx_s_q;
  logic rx_s;

  // NOTE: clocked state is written with <= so every flop samples the values
  // from before the edge; blocking = here would chain the two stages into one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_sig;
      rx_s_q  <= sync1_q;
    end
  end

  assign rx_s = rx_s_q;

  // ---------------------------------------------------------------------------
  // Sample value used at every sample point.
  // ---------------------------------------------------------------------------
  logic sample;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s at the count==1 cycle, hist_q[1] the cycle before it,
  // so at count==0 the three votes straddle the nominal mid-bit point.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s};
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [2:0]            state_q,   state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic                  deliver;
  logic                  stop_fail;
  logic                  cnt_zero;

  assign cnt_zero = (clk_cnt_q == '0);

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    stop_fail = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          clk_cnt_d = HALF_M1;
          state_d   = START;
        end
      end

      START: begin
        if (cnt_zero) begin
          if (!sample) begin
            bit_cnt_d = '0;
            clk_cnt_d = PULSE_M1;
            state_d   = DATA;
          end else begin
            // Line went back high before mid-start-bit: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_zero) begin
          // LSB arrives first, so shifting in from the top leaves it in bit 0.
          shift_d   = {sample, shift_q[DATA_WIDTH-1:1]};
          clk_cnt_d = PULSE_M1;
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_zero) begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back
          // start edge.
          if (sample) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            stop_fail = 1'b1;
            state_d   = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end

      BREAK: begin
        // A held-low line stays here, so it raises frame_err only once.
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and host handshake
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_q,        data_d;
  logic                  valid_q,       valid_d;
  logic                  frame_err_q,   frame_err_d;
  logic                  overrun_err_q, overrun_err_d;
  logic                  handshake;

  assign handshake = valid_q & ready_from_host;

  always_comb begin
    data_d        = data_q;
    valid_d       = valid_q;
    frame_err_d   = stop_fail;
    overrun_err_d = 1'b0;

    if (deliver) begin
      if (valid_q && !ready_from_host) begin
        // Host still owns the old word: keep it and drop the new one.
        overrun_err_d = 1'b1;
      end else begin
        // Either empty or the old word leaves this cycle; valid stays high.
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data_to_host  = data_q;
  assign valid_to_host = valid_q;
  assign frame_err     = frame_err_q;
  assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx.
//
// Two receivers share clk/rstn: u_full runs the default 868 clk/bit timing for
// the single-frame latency case and the long idle glitch; u_small runs at
// 16 clk/bit (half-bit 8) so the remaining frames stay short. The bench acts
// as the upstream transmitter, driving 8N1 frames bit by bit.
//
// Inputs change on the falling clock edge; a monitor observes outputs 2 time
// units after each falling edge, which is exactly what the next rising edge
// will use.
//
// Hand-derived timing (k = rising edges seen when the start bit is driven):
//   rx_s goes low after edge k+2, START is entered at edge k+3, the start bit
//   is sampled at edge k+3+HALF, the stop bit PW*9 later, and valid_to_host is
//   visible after that same edge -> latency 2+HALF+9*PW+1
//   (868 clk/bit: 8249, 16 clk/bit: 155).
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int PW_FULL  = 868;
  localparam int PW_SMALL = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_full, rx_small;
  logic       ready_full, ready_small;
  logic [7:0] data_full, data_small;
  logic       valid_full, valid_small;
  logic       ferr_full, ferr_small;
  logic       ovr_full, ovr_small;

  always #5 clk = ~clk;

  uart_rx u_full (
    .clk             (clk),
    .rstn            (rstn),
    .rx_sig          (rx_full),
    .data_to_host    (data_full),
    .valid_to_host   (valid_full),
    .ready_from_host (ready_full),
    .frame_err       (ferr_full),
    .overrun_err     (ovr_full)
  );

  uart_rx #(
    .DATA_WIDTH (8),
    .BAUD_RATE  (100_000),
    .CLK_FREQ   (1_600_000)
  ) u_small (
    .clk             (clk),
    .rstn            (rstn),
    .rx_sig          (rx_small),
    .data_to_host    (data_small),
    .valid_to_host   (valid_small),
    .ready_from_host (ready_small),
    .frame_err       (ferr_small),
    .overrun_err     (ovr_small)
  );

  // ---------------------------------------------------------------------------
  // Cycle counter and output monitors
  // ---------------------------------------------------------------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] acc_q[$];          // words accepted by the host side of u_small
  int         rises_small  = 0;
  int         last_rise    = 0;
  int         ferr_cycles  = 0;
  int         ovr_cycles   = 0;
  logic       prev_small   = 1'b0;

  int         rises_full   = 0;
  int         valid_cyc_full = 0;
  int         first_rise_full = 0;
  logic [7:0] first_data_full = 8'h00;
  int         flag_cyc_full = 0;
  logic       prev_full    = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (valid_small && ready_small) acc_q.push_back(data_small);
    if (valid_small && !prev_small) begin
      rises_small = rises_small + 1;
      last_rise   = cyc;
    end
    prev_small = valid_small;
    if (ferr_small) ferr_cycles = ferr_cycles + 1;
    if (ovr_small)  ovr_cycles  = ovr_cycles + 1;

    if (valid_full) valid_cyc_full = valid_cyc_full + 1;
    if (valid_full && !prev_full) begin
      rises_full = rises_full + 1;
      if (rises_full == 1) begin
        first_rise_full = cyc;
        first_data_full = data_full;
      end
    end
    prev_full = valid_full;
    if (ferr_full || ovr_full) flag_cyc_full = flag_cyc_full + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line drivers (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  int full_start  = 0;
  int small_start = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_line(input bit to_full, input logic v, input int n);
    if (to_full) rx_full = v;
    else         rx_small = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit to_full);
    int pw;
    pw = to_full ? PW_FULL : PW_SMALL;
    if (to_full) full_start = cyc;
    else         small_start = cyc;
    hold_line(to_full, 1'b0, pw);
    for (int i = 0; i < 8; i++) hold_line(to_full, b[i], pw);
    hold_line(to_full, stop_v, pw);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int         base;
  int         rises_before;
  logic [7:0] loop_bytes [4];

  initial begin
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h55;
    loop_bytes[3] = 8'hAA;

    rstn        = 1'b0;
    rx_full     = 1'b1;
    rx_small    = 1'b1;
    ready_full  = 1'b1;
    ready_small = 1'b1;
    wait_cyc(3);

    // Reset values
    check("rst_data",    32'(data_small),  32'h00);
    check("rst_valid",   32'(valid_small), 32'h0);
    check("rst_ferr",    32'(ferr_small),  32'h0);
    check("rst_ovr",     32'(ovr_small),   32'h0);
    check("rst_valid_full", 32'(valid_full), 32'h0);
    rstn = 1'b1;
    wait_cyc(5);
    check("idle_valid",  32'(valid_small), 32'h0);

    // 0xA5 at 868 clk/bit, host always ready
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_cyc(20);
    check("a5_rises",     32'(rises_full),      32'd1);
    check("a5_valid_len", 32'(valid_cyc_full),  32'd1);
    check("a5_data",      32'(first_data_full), 32'hA5);
    check("a5_lat_window",
          32'((first_rise_full - full_start >= 8248) && (first_rise_full - full_start <= 8250)),
          32'd1);
    check("a5_flags",     32'(flag_cyc_full),   32'd0);

    // 100-cycle low glitch on the idle line
    hold_line(1'b1, 1'b0, 100);
    hold_line(1'b1, 1'b1, 1000);
    check("glitch_full_rises", 32'(rises_full),    32'd1);
    check("glitch_full_flags", 32'(flag_cyc_full), 32'd0);

    // Short glitch (well under half a bit) on the 16 clk/bit receiver
    hold_line(1'b0, 1'b0, 4);
    hold_line(1'b0, 1'b1, 40);
    check("glitch_rises", 32'(rises_small), 32'd0);
    check("glitch_ferr",  32'(ferr_cycles), 32'd0);

    // 0x3C with stop bit low, line held low for a while, then released
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_line(1'b0, 1'b0, 5 * PW_SMALL);
    hold_line(1'b0, 1'b1, 40);
    check("ferr_pulse",   32'(ferr_cycles), 32'd1);
    check("ferr_novalid", 32'(rises_small), 32'd0);
    check("ferr_noovr",   32'(ovr_cycles),  32'd0);

    // 0x81 after the framing error; its latency is checked too
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(20);
    check("x81_rises", 32'(rises_small),             32'd1);
    check("x81_count", 32'(acc_q.size()),            32'd1);
    check("x81_data",  32'(acc_q[0]),                32'h81);
    check("x81_lat",   32'(last_rise - small_start), 32'd155);

    // Overrun: host stalled, 0x11 then 0x22 back to back
    ready_small = 1'b0;
    base = acc_q.size();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_cyc(20);
    check("ovr_valid",  32'(valid_small),  32'h1);
    check("ovr_data",   32'(data_small),   32'h11);
    check("ovr_pulse",  32'(ovr_cycles),   32'd1);
    check("ovr_rises",  32'(rises_small),  32'd2);
    check("ovr_held",   32'(acc_q.size()), 32'(base));
    ready_small = 1'b1;
    wait_cyc(3);
    check("ovr_consume_cnt",  32'(acc_q.size()), 32'(base + 1));
    check("ovr_consume_data", 32'(acc_q[base]),  32'h11);
    check("ovr_drained",      32'(valid_small),  32'h0);

    // Back-to-back loopback bytes, host ready
    base = acc_q.size();
    for (int i = 0; i < 4; i++) send_frame(loop_bytes[i], 1'b1, 1'b0);
    wait_cyc(20);
    check("loop_count", 32'(acc_q.size()), 32'(base + 4));
    for (int i = 0; i < 4; i++)
      check($sformatf("loop_data%0d", i), 32'(acc_q[base + i]), 32'(loop_bytes[i]));
    check("loop_ferr", 32'(ferr_cycles), 32'd1);
    check("loop_ovr",  32'(ovr_cycles),  32'd1);

    // Reset in the middle of 0x7E's data bits, held past the end of the frame
    base         = acc_q.size();
    rises_before = rises_small;
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      begin
        wait_cyc(60);
        rstn = 1'b0;
        wait_cyc(1);
        check("midrst_data",  32'(data_small),  32'h00);
        check("midrst_valid", 32'(valid_small), 32'h0);
        wait_cyc(109);
        rstn = 1'b1;
      end
    join
    wait_cyc(20);
    check("midrst_noword", 32'(rises_small), 32'(rises_before));
    check("midrst_ferr",   32'(ferr_cycles), 32'd1);
    check("midrst_ovr",    32'(ovr_cycles),  32'd1);

    send_frame(8'h42, 1'b1, 1'b0);
    wait_cyc(20);
    check("x42_count", 32'(acc_q.size()), 32'(base + 1));
    check("x42_data",  32'(acc_q[base]),  32'h42);
    check("x42_ferr",  32'(ferr_cycles),  32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver.
- Sits directly downstream of the UART transmitter on the serial line and consumes the 8N1 frames it produces.
- Recovers each frame by mid-bit sampling, then presents the payload word on a valid/ready handshake to the host-side logic.
- Flags framing errors and overruns.

Parameters:
DATA_WIDTH, 8, payload bits per frame, sent LSB first
BAUD_RATE, 115200, line bit rate in bit/s
CLK_FREQ, 100_000_000, clk frequency in Hz
PULSE_WIDTH (localparam), CLK_FREQ/BAUD_RATE, clocks per bit (868 at defaults)
HALF_PULSE_WIDTH (localparam), PULSE_WIDTH/2, clocks to mid-bit (434 at defaults)

Ports:
clk  input  1  system clock; the only clock
rstn  input  1  asynchronous, active-low reset
rx_sig  input  1  serial line, idle high, asynchronous to clk
data_to_host  output  DATA_WIDTH  received payload
valid_to_host  output  1  data_to_host holds an unconsumed word
ready_from_host  input  1  host accepts the word when valid_to_host && ready_from_host
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: a completed word was dropped

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values:
  - data_to_host=0, valid_to_host=0, frame_err=0, overrun_err=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Input synchronizer: rx_sig passes through 2 flops. All decisions use the synchronized value rx_s, which lags rx_sig by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rx_s is low, load clk_cnt=HALF_PULSE_WIDTH-1 and go to START.
- START: decrement clk_cnt. At clk_cnt==0, sample rx_s:
  - rx_s low: clear bit_cnt, load clk_cnt=PULSE_WIDTH-1, go to DATA.
  - rx_s high: treat as a glitch and return to IDLE. No flags.
- DATA: at clk_cnt==0, shift rx_s into the shift register MSB side, so that after DATA_WIDTH bits bit 0 holds the first-received bit. Reload clk_cnt=PULSE_WIDTH-1. After bit DATA_WIDTH-1, go to STOP.
- STOP: at clk_cnt==0, sample rx_s:
  - rx_s high: deliver the word (see output rules) and go to IDLE.
  - Returning at mid-stop-bit allows back-to-back frames with no idle gap.
  - rx_s low: pulse frame_err for 1 cycle, discard the word, go to BREAK.
- BREAK: wait until rx_s is high, then go to IDLE. Holding the line low never causes repeated frame_err.
- Output register and handshake:
  - Deliver: the cycle after the STOP sample, data_to_host=word and valid_to_host=1.
  - valid_to_host and data_to_host stay stable until the handshake completes.
  - On handshake with no delivery in the same cycle, valid_to_host drops to 0 the next cycle.
  - Delivery while valid_to_host=1 and ready_from_host=0: new word is dropped, old word is kept, overrun_err pulses for 1 cycle.
  - Delivery in the same cycle as a handshake: new word loads, valid_to_host stays 1, no overrun.
- Latency: start edge on rx_sig to valid_to_host is 2 + HALF_PULSE_WIDTH + (DATA_WIDTH+1)·PULSE_WIDTH + 1 cycles, ±1.
- Counter widths: clk_cnt is $clog2(PULSE_WIDTH)+1 bits; bit_cnt is $clog2(DATA_WIDTH)+1 bits. No wrap-around in normal operation.
- Reset mid-frame: all state returns to reset values immediately. The partial word is lost and no flags are raised.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined:
  - Every sample point (START, DATA, STOP) uses a 2-of-3 majority of rx_s taken at count values 1, 0 and the cycle before count 1.
  - The sample register is clocked every cycle and tracks rx_s.
  - Single-cycle line glitches at a sample point are rejected.
  - Latency is unchanged.
- Undefined: a single sample of rx_s at clk_cnt==0.

Test Plan:
- Frame 0xA5 at 868 clk/bit, ready_from_host=1 → valid_to_host for exactly 1 cycle with data_to_host=0xA5, about 8248 cycles after the start edge. No flags.
- 100-cycle low glitch on idle rx_sig → no valid_to_host, no flags, FSM back in IDLE.
- Frame 0x3C with stop bit driven low, then line high → frame_err one pulse, no valid_to_host. Next frame 0x81 is received correctly.
- ready_from_host=0, frames 0x11 then 0x22 back-to-back → data_to_host=0x11 stays valid, overrun_err one pulse at the end of the second frame. Raising ready consumes 0x11, then valid_to_host=0.
- Loopback from uart_tx with bytes 0x00, 0xFF, 0x55, 0xAA and ready=1 → all four received in order, no flags.
- rstn asserted mid-DATA of 0x7E, released, then frame 0x42 sent → no output for 0x7E; 0x42 received correctly.
